// File: rtl/hier_tree_node.sv
`default_nettype none
// ============================================================================
// Module      : hier_tree_node
// Description : N-way node of the hierarchy tree. Merges NUM_CHILDREN child
//               valid/ready streams into one upstream stream through a
//               round-robin arbiter and a single registered output entry.
//               up_id tags the child slot that supplied up_data.
//               Optional per-child grant counters are built when the macro
//               HIER_NODE_STATS_EN is defined (adds stat_sel/stat_count).
// Revision    : 1.0 - initial release
// ============================================================================
module hier_tree_node #(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 16,
    localparam int ID_W        = $clog2(NUM_CHILDREN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    output logic                           up_valid,
    output logic [DATA_W-1:0]              up_data,
    output logic [ID_W-1:0]                up_id,
    input  logic                           up_ready,
    output logic                           busy
`ifdef HIER_NODE_STATS_EN
    ,
    input  logic [ID_W-1:0]                stat_sel,
    output logic [CNT_W-1:0]               stat_count
`endif
);

    localparam logic [ID_W:0]   c_n_ext = (ID_W+1)'(NUM_CHILDREN);
    localparam logic [ID_W-1:0] c_last  = ID_W'(NUM_CHILDREN-1);

    logic                    r_up_valid;
    logic [DATA_W-1:0]       r_up_data;
    logic [ID_W-1:0]         r_up_id;
    logic [ID_W-1:0]         r_ptr;

    logic                    w_accept;
    logic                    w_any;
    logic                    w_take;
    logic [ID_W-1:0]         w_win;
    logic [ID_W:0]           w_sum;
    logic [NUM_CHILDREN-1:0] w_grant;
    logic [ID_W-1:0]         w_ptr_next;
    logic [DATA_W-1:0]       w_child_data [NUM_CHILDREN];

    // Slice the flat child payload bus into one word per child slot.
    for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_unpack
        assign w_child_data[g] = child_data[g*DATA_W +: DATA_W];
    end

    // Entry can take a new item when empty or draining this cycle; reset
    // blocks acceptance so nothing is granted while rst is high.
    assign w_accept = (!r_up_valid || up_ready) && !rst;

    // Round-robin scan starting at r_ptr; scanning offsets from the top down
    // leaves the smallest offset (first valid child after ptr) as the winner.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int k = NUM_CHILDREN-1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= c_n_ext) begin
                w_sum = w_sum - c_n_ext;
            end
            if (child_valid[w_sum[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_grant     = w_any ? (NUM_CHILDREN'(1) << w_win) : '0;
    assign child_ready = w_grant & {NUM_CHILDREN{w_accept}};
    assign w_take      = w_accept && w_any;
    assign w_ptr_next  = (w_win == c_last) ? '0 : w_win + ID_W'(1);

    // Output entry: load on a child transfer (replacing in place if the
    // parent drains simultaneously), clear on a drain with no refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_valid <= 1'b0;
            r_up_data  <= '0;
            r_up_id    <= '0;
            r_ptr      <= '0;
        end else if (w_take) begin
            r_up_valid <= 1'b1;
            r_up_data  <= w_child_data[w_win];
            r_up_id    <= w_win;
            r_ptr      <= w_ptr_next;
        end else if (r_up_valid && up_ready) begin
            r_up_valid <= 1'b0;
        end
    end

    assign up_valid = r_up_valid;
    assign up_data  = r_up_data;
    assign up_id    = r_up_id;
    assign busy     = (|child_valid) || r_up_valid;

`ifdef HIER_NODE_STATS_EN
    logic [CNT_W-1:0] w_cnt [NUM_CHILDREN];

    for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_stat
        logic [CNT_W-1:0] r_cnt;

        // Saturating count of transfers accepted from this child.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (child_valid[g] && child_ready[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt[g] = r_cnt;
    end

    // Selects beyond the last child slot read as zero.
    assign stat_count = ({1'b0, stat_sel} < c_n_ext) ? w_cnt[stat_sel] : '0;
`endif

endmodule
`default_nettype wire
